// File: rtl/bike_bram_stream_reader_pkg.sv
// Shared constants, sizing helper and FSM state type for the BIKE BRAM stream reader.
// Constants below describe the default build (R_BITS = 12323, B_WIDTH = 128).
package bike_bram_stream_reader_pkg;

  function automatic int unsigned div_and_ceil(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  localparam int unsigned R_BITS_DEF  = 12323;
  localparam int unsigned B_WIDTH_DEF = 128;
  localparam int unsigned SWORDS      = div_and_ceil(R_BITS_DEF, B_WIDTH_DEF);
  localparam int unsigned LOGSWORDS   = $clog2(SWORDS);
  localparam int unsigned DWORDS      = div_and_ceil(R_BITS_DEF, 32);
  localparam int unsigned TAIL_BITS   = R_BITS_DEF % 32;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} reader_state_t;

endpackage

// File: rtl/bike_bram_stream_reader_if.sv
// Memory read port plus 32-bit valid/ready output stream of the BIKE BRAM stream reader.
interface bike_bram_stream_reader_if #(
  parameter int unsigned B_WIDTH   = bike_bram_stream_reader_pkg::B_WIDTH_DEF,
  parameter int unsigned LOGSWORDS = bike_bram_stream_reader_pkg::LOGSWORDS
);
  logic                 mem_ren;
  logic [LOGSWORDS-1:0] mem_addr;
  logic [B_WIDTH-1:0]   mem_dout;
  logic                 m_valid;
  logic                 m_ready;
  logic [31:0]          m_data;
  logic                 m_last;

  modport master (
    output mem_ren, mem_addr, m_valid, m_data, m_last,
    input  mem_dout, m_ready
  );

  modport slave (
    input  mem_ren, mem_addr, m_valid, m_data, m_last,
    output mem_dout, m_ready
  );
endinterface

// File: rtl/bike_bram_stream_reader_serializer.sv
// Splits B_WIDTH memory words into 32-bit stream words, counts output words,
// drops the unused sub-words of the last memory word and masks the tail word.
module bike_word_serializer #(
  parameter int unsigned B_WIDTH   = 128,
  parameter int unsigned DWORDS    = 386,
  parameter int unsigned TAIL_BITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               src_valid,
  input  logic [B_WIDTH-1:0] src_data,
  output logic               take_c,
  output logic               final_accept_c,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [31:0]        m_data,
  output logic               m_last
);

  localparam int unsigned NSUB  = B_WIDTH / 32;
  localparam int unsigned IDX_W = (NSUB > 1) ? $clog2(NSUB) : 1;
  localparam int unsigned CNT_W = $clog2(DWORDS + 1);
  localparam logic [31:0] TAIL_MASK = (TAIL_BITS == 0) ? 32'hFFFF_FFFF
                                                       : 32'((64'd1 << TAIL_BITS) - 64'd1);

  logic [B_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               valid;
  logic               accept;
  logic               is_final;
  logic               last_sub;
  logic [31:0]        word_sel;

  assign accept   = valid && m_ready;
  assign is_final = (cnt == CNT_W'(DWORDS - 1));
  // The final stream word ends its memory word even if more lanes remain.
  assign last_sub = (idx == IDX_W'(NSUB - 1)) || is_final;
  assign take_c   = !valid || (accept && last_sub);
  assign final_accept_c = accept && is_final;

  assign word_sel = 32'(shreg >> (32 * idx));
  assign m_valid  = valid;
  assign m_data   = is_final ? (word_sel & TAIL_MASK) : word_sel;
  assign m_last   = valid && is_final;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      idx   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + CNT_W'(1);
      if (take_c) begin
        if (src_valid) begin
          shreg <= src_data;
          idx   <= '0;
          valid <= 1'b1;
        end else begin
          valid <= 1'b0;
        end
      end else if (accept) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/bike_bram_stream_reader.sv
// Reads one R_BITS polynomial from the BIKE BRAM wrapper and streams it out as 32-bit words.
// Optional macro BIKE_READER_STALL_CNT_EN adds a saturating back-pressure cycle counter.
module bike_bram_stream_reader
  import bike_bram_stream_reader_pkg::*;
#(
  parameter int unsigned B_WIDTH   = 128,
  parameter int unsigned R_BITS    = 12323,
  parameter int unsigned SWORDS    = div_and_ceil(R_BITS, B_WIDTH),
  parameter int unsigned LOGSWORDS = $clog2(SWORDS),
  parameter int unsigned DWORDS    = div_and_ceil(R_BITS, 32)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  bike_bram_stream_reader_if.master bus
`ifdef BIKE_READER_STALL_CNT_EN
  , output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned TAIL_BITS = R_BITS % 32;
  localparam int unsigned RA_W      = $clog2(SWORDS + 1);

  reader_state_t        state;
  logic [RA_W-1:0]      rd_addr;
  logic [LOGSWORDS-1:0] addr_q;
  logic                 inflight;
  logic                 pf_valid;
  logic [B_WIDTH-1:0]   pf_data;
  logic                 take_c;
  logic                 final_accept_c;
  logic                 issue_c;
  logic                 start_acc_c;

  assign start_acc_c = (state == IDLE) && start;
  // Issue only when the returning word is guaranteed a free slot.
  assign issue_c = (state == RUN) && (rd_addr < RA_W'(SWORDS)) && !inflight
                   && (!pf_valid || take_c);
  assign bus.mem_ren  = issue_c;
  assign bus.mem_addr = issue_c ? LOGSWORDS'(rd_addr) : addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_addr  <= '0;
      addr_q   <= '0;
      inflight <= 1'b0;
      pf_valid <= 1'b0;
      pf_data  <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= issue_c;
      if (issue_c) begin
        addr_q  <= LOGSWORDS'(rd_addr);
        rd_addr <= rd_addr + RA_W'(1);
      end
      // Returning data bypasses straight to the serializer when it can take it.
      if (pf_valid) begin
        if (take_c) begin
          pf_valid <= inflight;
          pf_data  <= bus.mem_dout;
        end
      end else if (inflight && !take_c) begin
        pf_valid <= 1'b1;
        pf_data  <= bus.mem_dout;
      end
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          rd_addr  <= '0;
          inflight <= 1'b0;
          pf_valid <= 1'b0;
        end
        RUN: if (final_accept_c) begin
          state <= FLUSH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bike_word_serializer #(
    .B_WIDTH  (B_WIDTH),
    .DWORDS   (DWORDS),
    .TAIL_BITS(TAIL_BITS)
  ) u_ser (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_acc_c),
    .src_valid     (pf_valid || inflight),
    .src_data      (pf_valid ? pf_data : bus.mem_dout),
    .take_c        (take_c),
    .final_accept_c(final_accept_c),
    .m_ready       (bus.m_ready),
    .m_valid       (bus.m_valid),
    .m_data        (bus.m_data),
    .m_last        (bus.m_last)
  );

`ifdef BIKE_READER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc_c) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && bus.m_valid && !bus.m_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
